// File: rtl/kudu_if_pkg.sv
// Shared fetch-side definitions: aligner state encoding, the RVC opcode marker
// and the boot address used by both the fetch unit and the aligner.
package kudu_if_pkg;

  typedef enum logic [1:0] {
    ALIGN_EMPTY = 2'b00,
    ALIGN_HALF  = 2'b01,
    ALIGN_SKIP  = 2'b10
  } if_align_state_e;

  localparam logic [1:0]  RvcOpcodeFull = 2'b11;
  localparam logic [31:0] BootAddr      = 32'h0000_0080;

  // A halfword starts a compressed instruction unless its low opcode bits are 2'b11.
  function automatic logic is_compressed(input logic [1:0] op);
    return op != RvcOpcodeFull;
  endfunction

endpackage

// File: rtl/if_aligner.sv
// Fetch-side aligner: turns 32-bit fetch words into whole RV32 instructions.
// Define IF_ALIGN_RVC_EN to support 16-bit compressed instructions.
module if_aligner
  import kudu_if_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fifo_valid_i,
  input  logic [31:0] fifo_data_i,
  input  logic        fifo_err_i,
  output logic        fifo_rdy_o,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_c_o,
  output logic        instr_err_o,
  input  logic        instr_rdy_i
);

  logic [31:1] pc_q, pc_d;

  assign instr_pc_o = {pc_q, 1'b0};

`ifdef IF_ALIGN_RVC_EN

  if_align_state_e state_q, state_d;
  logic [15:0]     res_q, res_d;
  logic            res_err_q, res_err_d;
  logic            unused_flush_pc;

  assign unused_flush_pc = flush_pc_i[0];

  // State, residue and PC registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ALIGN_EMPTY;
      res_q     <= 16'h0000;
      res_err_q <= 1'b0;
      pc_q      <= BootAddr[31:1];
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      res_err_q <= res_err_d;
      pc_q      <= pc_d;
    end
  end

  // Instruction selection, handshakes and next-state logic.
  always_comb begin
    state_d       = state_q;
    res_d         = res_q;
    res_err_d     = res_err_q;
    pc_d          = pc_q;
    instr_valid_o = 1'b0;
    fifo_rdy_o    = 1'b0;
    instr_o       = fifo_data_i;
    instr_is_c_o  = 1'b0;
    instr_err_o   = fifo_err_i;
    case (state_q)
      ALIGN_EMPTY: begin
        instr_valid_o = fifo_valid_i;
        fifo_rdy_o    = fifo_valid_i & instr_rdy_i;
        if (is_compressed(fifo_data_i[1:0])) begin
          instr_o      = {16'h0000, fifo_data_i[15:0]};
          instr_is_c_o = 1'b1;
          if (fifo_rdy_o) begin
            res_d     = fifo_data_i[31:16];
            res_err_d = fifo_err_i;
            state_d   = ALIGN_HALF;
          end else begin
            state_d   = ALIGN_EMPTY;
          end
        end else begin
          state_d = ALIGN_EMPTY;
        end
      end
      ALIGN_HALF: begin
        if (is_compressed(res_q[1:0])) begin
          // The residue is a full instruction on its own; the FIFO waits.
          instr_valid_o = 1'b1;
          instr_o       = {16'h0000, res_q};
          instr_is_c_o  = 1'b1;
          instr_err_o   = res_err_q;
          if (instr_rdy_i) begin
            state_d = ALIGN_EMPTY;
          end else begin
            state_d = ALIGN_HALF;
          end
        end else begin
          instr_valid_o = fifo_valid_i;
          fifo_rdy_o    = fifo_valid_i & instr_rdy_i;
          instr_o       = {fifo_data_i[15:0], res_q};
          instr_err_o   = res_err_q | fifo_err_i;
          if (fifo_rdy_o) begin
            res_d     = fifo_data_i[31:16];
            res_err_d = fifo_err_i;
          end else begin
            res_d     = res_q;
          end
        end
      end
      ALIGN_SKIP: begin
        fifo_rdy_o = 1'b1;
        if (fifo_valid_i) begin
          res_d     = fifo_data_i[31:16];
          res_err_d = fifo_err_i;
          state_d   = ALIGN_HALF;
        end else begin
          state_d   = ALIGN_SKIP;
        end
      end
      default: begin
        state_d = ALIGN_EMPTY;
      end
    endcase

    if (instr_valid_o && instr_rdy_i) begin
      pc_d = pc_q + (instr_is_c_o ? 31'd1 : 31'd2);
    end else begin
      pc_d = pc_q;
    end

    // A redirect overrides any handshake computed above.
    if (flush_i) begin
      instr_valid_o = 1'b0;
      fifo_rdy_o    = 1'b0;
      pc_d          = flush_pc_i[31:1];
      state_d       = flush_pc_i[1] ? ALIGN_SKIP : ALIGN_EMPTY;
      res_d         = 16'h0000;
      res_err_d     = 1'b0;
    end else begin
      res_err_d     = res_err_d;
    end
  end

`else

  logic unused_flush_pc;

  assign unused_flush_pc = ^flush_pc_i[1:0];

  // PC register; without RVC every fetch word is one instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= BootAddr[31:1];
    end else begin
      pc_q <= pc_d;
    end
  end

  // Pass-through of whole words with PC tracking.
  always_comb begin
    instr_o       = fifo_data_i;
    instr_is_c_o  = 1'b0;
    instr_err_o   = fifo_err_i;
    instr_valid_o = fifo_valid_i & ~flush_i;
    fifo_rdy_o    = fifo_valid_i & instr_rdy_i & ~flush_i;
    pc_d          = pc_q;
    if (flush_i) begin
      pc_d = {flush_pc_i[31:2], 1'b0};
    end else if (fifo_rdy_o) begin
      pc_d = pc_q + 31'd2;
    end else begin
      pc_d = pc_q;
    end
  end

`endif

endmodule

// File: tb/tb_if_aligner.sv
// Table-driven bench for if_aligner; one row per clock cycle, outputs
// sampled 1ns after the inputs change on the falling edge.
module tb_if_aligner;
  import kudu_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = 32'h0;
  logic        fifo_valid_i = 1'b0;
  logic [31:0] fifo_data_i = 32'h0;
  logic        fifo_err_i = 1'b0;
  logic        fifo_rdy_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_is_c_o;
  logic        instr_err_o;
  logic        instr_rdy_i = 1'b1;

  always #5 clk = ~clk;

  if_aligner dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fifo_valid_i(fifo_valid_i), .fifo_data_i(fifo_data_i), .fifo_err_i(fifo_err_i),
    .fifo_rdy_o(fifo_rdy_o), .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .instr_is_c_o(instr_is_c_o), .instr_err_o(instr_err_o),
    .instr_rdy_i(instr_rdy_i)
  );

  typedef struct {
    logic        rst_n;
    logic        fl;
    logic [31:0] fpc;
    logic        fv;
    logic [31:0] fd;
    logic        fe;
    logic        rdy;
    logic        e_iv;
    logic        e_frdy;
    logic        e_c;
    logic        e_err;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic rst_n, logic fl, logic [31:0] fpc, logic fv,
                              logic [31:0] fd, logic fe, logic rdy, logic e_iv,
                              logic e_frdy, logic e_c, logic e_err, logic [31:0] e_pc,
                              logic [31:0] e_instr);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.fpc = fpc; v.fv = fv; v.fd = fd; v.fe = fe; v.rdy = rdy;
    v.e_iv = e_iv; v.e_frdy = e_frdy; v.e_c = e_c; v.e_err = e_err;
    v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst_ni = v.rst_n; flush_i = v.fl; flush_pc_i = v.fpc; fifo_valid_i = v.fv;
    fifo_data_i = v.fd; fifo_err_i = v.fe; instr_rdy_i = v.rdy;
    #1;
  endtask

  // Data fields are only meaningful while an instruction is presented.
  task automatic apply(input vec_t v, input int idx);
    drive(v);
    checks++;
    if (instr_valid_o !== v.e_iv || fifo_rdy_o !== v.e_frdy || instr_pc_o !== v.e_pc ||
        (v.e_iv && (instr_o !== v.e_instr || instr_is_c_o !== v.e_c ||
                    instr_err_o !== v.e_err))) begin
      failures++;
      $display("FAIL vec%0d: got valid=%b rdy=%b pc=%h instr=%h c=%b err=%b, want valid=%b rdy=%b pc=%h instr=%h c=%b err=%b",
               idx, instr_valid_o, fifo_rdy_o, instr_pc_o, instr_o, instr_is_c_o, instr_err_o,
               v.e_iv, v.e_frdy, v.e_pc, v.e_instr, v.e_c, v.e_err);
    end
  endtask

  initial begin
    int pops;
`ifdef IF_ALIGN_RVC_EN
    //               rst fl fpc           fv fd            fe rdy  iv fr c  er pc            instr
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 0, 0, 0, 32'h00000080, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00A00093, 0, 1,   1, 1, 0, 0, 32'h00000080, 32'h00A00093));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00108113, 0, 1,   1, 1, 0, 0, 32'h00000084, 32'h00108113));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00014501, 0, 1,   1, 1, 1, 0, 32'h00000088, 32'h00004501));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00000013, 0, 1,   1, 0, 1, 0, 32'h0000008A, 32'h00000001));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00000013, 0, 1,   1, 1, 0, 0, 32'h0000008C, 32'h00000013));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00934501, 0, 1,   1, 1, 1, 0, 32'h00000090, 32'h00004501));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 1,   0, 0, 0, 0, 32'h00000092, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h000000A0, 0, 1,   1, 1, 0, 0, 32'h00000092, 32'h00A00093));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 1,   1, 0, 1, 0, 32'h00000096, 32'h00000000));
    vecs.push_back(mk(1, 1, 32'h00000102, 1, 32'h00000013, 0, 1,   0, 0, 0, 0, 32'h00000098, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h0001FFFF, 0, 1,   0, 1, 0, 0, 32'h00000102, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 1,   1, 0, 1, 0, 32'h00000102, 32'h00000001));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00134501, 0, 1,   1, 1, 1, 0, 32'h00000104, 32'h00004501));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00010000, 1, 0,   1, 0, 0, 1, 32'h00000106, 32'h00000013));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00010000, 1, 0,   1, 0, 0, 1, 32'h00000106, 32'h00000013));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00010000, 1, 0,   1, 0, 0, 1, 32'h00000106, 32'h00000013));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00010000, 1, 1,   1, 1, 0, 1, 32'h00000106, 32'h00000013));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 1,   1, 0, 1, 1, 32'h0000010A, 32'h00000001));
    vecs.push_back(mk(1, 1, 32'h00000200, 1, 32'h00A00093, 0, 1,   0, 0, 0, 0, 32'h0000010C, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00A00093, 0, 1,   1, 1, 0, 0, 32'h00000200, 32'h00A00093));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00014501, 0, 1,   1, 1, 1, 0, 32'h00000204, 32'h00004501));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 0, 0, 0, 32'h00000080, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00000013, 0, 1,   1, 1, 0, 0, 32'h00000080, 32'h00000013));
    vecs.push_back(mk(1, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 1,   0, 0, 0, 0, 32'h00000084, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00000013, 0, 1,   1, 1, 0, 0, 32'hFFFFFFFC, 32'h00000013));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 1,   0, 0, 0, 0, 32'h00000000, 32'h0));
    vecs.push_back(mk(1, 1, 32'h00000301, 0, 32'h0,        0, 1,   0, 0, 0, 0, 32'h00000000, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00000013, 0, 1,   1, 1, 0, 0, 32'h00000300, 32'h00000013));
`else
    //               rst fl fpc           fv fd            fe rdy  iv fr c  er pc            instr
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 0, 0, 0, 32'h00000080, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00A00093, 0, 1,   1, 1, 0, 0, 32'h00000080, 32'h00A00093));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00108113, 0, 1,   1, 1, 0, 0, 32'h00000084, 32'h00108113));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00014501, 0, 1,   1, 1, 0, 0, 32'h00000088, 32'h00014501));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00000013, 0, 1,   1, 1, 0, 0, 32'h0000008C, 32'h00000013));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00000013, 1, 0,   1, 0, 0, 1, 32'h00000090, 32'h00000013));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00000013, 1, 1,   1, 1, 0, 1, 32'h00000090, 32'h00000013));
    vecs.push_back(mk(1, 1, 32'h00000102, 1, 32'h00000013, 0, 1,   0, 0, 0, 0, 32'h00000094, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h0001FFFF, 0, 1,   1, 1, 0, 0, 32'h00000100, 32'h0001FFFF));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 0, 0, 0, 32'h00000080, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 1,   0, 0, 0, 0, 32'h00000080, 32'h0));
    vecs.push_back(mk(1, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 1,   0, 0, 0, 0, 32'h00000080, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h00000013, 0, 1,   1, 1, 0, 0, 32'hFFFFFFFC, 32'h00000013));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 1,   0, 0, 0, 0, 32'h00000000, 32'h0));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Back-to-back aligned words after reset: one pop per cycle, PC +4 each.
    drive(mk(0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0));
    pops = 0;
    for (int i = 0; i < 4; i++) begin
      drive(mk(1, 0, 32'h0, 1, 32'h00000013, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0));
      if (fifo_rdy_o === 1'b1) pops++;
    end
    drive(mk(1, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0));
    checks++;
    if (pops != 4) begin
      failures++;
      $display("FAIL burst_pops: got %0d, want 4", pops);
    end
    checks++;
    if (instr_pc_o !== 32'h00000090) begin
      failures++;
      $display("FAIL burst_pc: got %h, want 00000090", instr_pc_o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_aligner.md
# if_aligner

Fetch-side instruction aligner. It sits directly downstream of the fetch write-through FIFO and consumes 32-bit fetch words through a valid/ready handshake. It splits or stitches those words into whole RV32 instructions (16-bit compressed or 32-bit), each tagged with its PC, and passes them to the decoder, also through a valid/ready handshake. It holds at most one leftover halfword between cycles.

## Interface
- BootAddr, 32'h0000_0080, PC loaded at reset; bit 0 ignored.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  redirect; discards residue and restarts at flush_pc_i.
- flush_pc_i  in  32  redirect target; bit 0 ignored.
- fifo_valid_i  in  1  fetch word available.
- fifo_data_i  in  32  fetch word (little-endian, word-aligned address).
- fifo_err_i  in  1  bus error on this fetch word.
- fifo_rdy_o  out  1  word consumed this cycle.
- instr_valid_o  out  1  instruction presented.
- instr_o  out  32  instruction; compressed instructions are zero-extended in [15:0].
- instr_pc_o  out  32  PC of instr_o.
- instr_is_c_o  out  1  instr_o is 16-bit.
- instr_err_o  out  1  a contributing halfword came from an errored word.
- instr_rdy_i  in  1  decoder accepts.

## Operation
- Registers:
  - state_q: EMPTY, HALF or SKIP.
  - res_q[15:0]: leftover halfword.
  - res_err_q.
  - pc_q[31:1]: PC of the next instruction to emit.
- Halfword h is compressed iff h[1:0] != 2'b11.
- EMPTY:
  - Compressed low half: emit fifo_data_i[15:0]. On handshake, consume the word, set res_q=fifo_data_i[31:16], go HALF.
  - Otherwise: emit the full word. On handshake, consume it and stay EMPTY.
- HALF, res_q compressed:
  - Emit res_q with instr_err_o=res_err_q.
  - fifo_rdy_o=0. The FIFO is not needed, so fifo_valid_i is ignored.
  - On handshake go EMPTY.
- HALF, res_q 32-bit:
  - Needs the FIFO; emit {fifo_data_i[15:0],res_q}, err=res_err_q|fifo_err_i.
  - On handshake: consume the word, res_q=fifo_data_i[31:16], stay HALF.
- SKIP (entered after a flush to a PC with bit 1 set):
  - fifo_rdy_o=1 and instr_valid_o=0.
  - On fifo_valid_i: latch fifo_data_i[31:16] and the error into res_q/res_err_q, go HALF. The low half is discarded.
- instr_valid_o is asserted only when a complete instruction is available (rules above). fifo_rdy_o is asserted only on the consumption conditions above.
- pc_q advances by 2 (compressed) or 4 on each instr_valid_o&&instr_rdy_i.
- Arithmetic: pc_q wraps modulo 2^32 with no special handling. instr_pc_o = {pc_q,1'b0}.
- flush_i has priority over any handshake in the same cycle:
  - instr_valid_o and fifo_rdy_o are forced 0.
  - pc_q<=flush_pc_i[31:1].
  - state_q<=flush_pc_i[1] ? SKIP : EMPTY.
  - res_q is cleared.
- Errored words: fetch continues normally. Treating the error is the decoder's job.

## Timing
- Zero-latency combinational path: fifo_data_i to instr_o, and instr_rdy_i to fifo_rdy_o. There are no output registers.
- The state update and PC advance take effect at the next clk_i edge.
- Reset (rst_ni low) values:
  - state_q=EMPTY, pc_q=BootAddr[31:1], res_q=0, res_err_q=0.
  - Outputs: instr_pc_o=BootAddr, instr_valid_o=fifo_valid_i (0 from the reset FIFO), fifo_rdy_o=0, instr_is_c_o and instr_err_o from fifo_data_i.
- Reset asserted mid-operation drops the residue immediately (asynchronous).
- instr_valid_o must stay stable until accepted unless flush_i is asserted. instr_valid_o must not depend on instr_rdy_i.
- Throughput:
  - One instruction per cycle when the FIFO is non-empty.
  - Two compressed instructions from one word take two cycles but one FIFO pop.
  - A flush to an unaligned PC costs one extra cycle (SKIP).

## Configuration
- IF_ALIGN_RVC_EN defined: full behaviour above.
- IF_ALIGN_RVC_EN undefined:
  - Only the EMPTY state exists; every word is one 32-bit instruction.
  - instr_is_c_o=0 and instr_err_o=fifo_err_i.
  - pc_q advances by 4; flush_pc_i[1] is ignored (treated as 0).
  - res_q and SKIP are removed from the RTL.

## Structure
- Shared package kudu_if_pkg holds:
  - typedef enum logic [1:0] if_align_state_e {ALIGN_EMPTY, ALIGN_HALF, ALIGN_SKIP};
  - constant RvcOpcodeFull = 2'b11;
  - the BootAddr default, shared with the fetch unit.
- No sub-module. RVC expansion is the decoder's responsibility.

## Test plan
- Aligned 32-bit stream, reset then words 32'h00A00093, 32'h00108113 back to back with instr_rdy_i=1:
  - instr_o matches each word, PCs 0x80 and 0x84, is_c=0.
  - Two FIFO pops in two cycles.
- Mixed word 32'h0001_4501 (c.li a0,0 low, c.nop high), then 32'h00000013:
  - Emits 0x4501 at PC 0x80 with a pop, then 0x0001 at 0x82 with fifo_rdy_o=0, then 0x00000013 at 0x84.
- Straddling 32-bit instruction: words 32'h0093_4501 then 32'h0000_00A0:
  - Emits 0x4501 at 0x80.
  - Emits 32'h00A00093 at 0x82 in the cycle the second word is present.
- Flush to 32'h0000_0102, then word 32'h0001_FFFF:
  - SKIP pops the word with no valid output.
  - Next cycle emits 0x0001 at PC 0x102, is_c=1.
- Error straddle: first word err=0 with a 32-bit high half, second word err=1:
  - Stitched instruction has instr_err_o=1.
  - Also hold instr_rdy_i=0 for 3 cycles: outputs stay stable and no pops occur.
- flush_i asserted together with a pending handshake: no pop, PC = flush target next cycle. Separately, rst_ni pulsed low in HALF: state EMPTY and PC=BootAddr immediately.
